// File: rtl/tiny_alu_core_pkg.sv
// Shared types for the tiny ALU core: operation encoding, FSM states and default sizing.
package tiny_alu_core_pkg;

   localparam int OP_W        = 3;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_MUL_LAT = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP  = 3'b000,
      OP_ADD  = 3'b001,
      OP_AND  = 3'b010,
      OP_XOR  = 3'b011,
      OP_MUL  = 3'b100,
      OP_ILL5 = 3'b101,
      OP_ILL6 = 3'b110,
      OP_RST  = 3'b111
   } operation_t;

   typedef enum logic [1:0] {
      IDLE,
      MUL_BUSY,
      WAIT_LOW
   } alu_state_t;

endpackage

// File: rtl/alu_mul_pipe.sv
// Unsigned multiplier pipeline: product formed at capture, then carried down a valid/data
// shift chain. Reset clears the valid chain so an in-flight product can never emerge.
module alu_mul_pipe #(
   parameter int DATA_W = 8,
   parameter int STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  out_valid,
   output logic [2*DATA_W-1:0]   out_prod
);

   localparam int RES_W = 2 * DATA_W;

   logic [STAGES-1:0] valid_q, valid_d;
   logic [RES_W-1:0]  prod_q [STAGES];
   logic [RES_W-1:0]  prod_d [STAGES];

   always_comb begin
      valid_d    = '0;
      prod_d     = '{default: '0};
      valid_d[0] = in_valid;
      prod_d[0]  = in_valid ? (RES_W'(a) * RES_W'(b)) : prod_q[0];
      for (int i = 1; i < STAGES; i++) begin
         valid_d[i] = valid_q[i-1];
         prod_d[i]  = prod_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         prod_q  <= '{default: '0};
      end else begin
         valid_q <= valid_d;
         prod_q  <= prod_d;
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign out_prod  = prod_q[STAGES-1];

endmodule

// File: rtl/tiny_alu_core.sv
// ALU core: accepts one command per start request, returns add/and/xor in one cycle and
// multiply after MUL_LAT cycles, with a one-cycle done pulse alongside a registered result.
module tiny_alu_core
   import tiny_alu_core_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MUL_LAT = DEF_MUL_LAT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     A,
   input  logic [DATA_W-1:0]     B,
   input  logic [OP_W-1:0]       op,
   input  logic                  start,
   output logic                  done,
   output logic [2*DATA_W-1:0]   result
);

   localparam int RES_W = 2 * DATA_W;

   // Handshake: start is a level request. A command is accepted on a rising edge in IDLE with
   // start high; done pulses once when its result lands, and the FSM only rearms after the
   // master has dropped start, so a request still held after done never issues a second command.

   logic rst_meta_q, rst_sync_n_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_meta_q   <= 1'b0;
         rst_sync_n_q <= 1'b0;
      end else begin
         rst_meta_q   <= 1'b1;
         rst_sync_n_q <= rst_meta_q;
      end
   end

   alu_state_t       state_q, state_d;
   logic             done_q, done_d;
   logic [RES_W-1:0] result_q, result_d;
   logic [RES_W-1:0] simple_res;
   logic             is_simple, is_mul, accept_mul;
   logic             mul_valid;
   logic [RES_W-1:0] mul_prod;

   assign is_simple  = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);
   assign is_mul     = (op == OP_MUL);
   assign accept_mul = (state_q == IDLE) && start && is_mul;

   always_comb begin
      simple_res = '0;
      case (op)
         OP_ADD:  simple_res = RES_W'({1'b0, A} + {1'b0, B});
         OP_AND:  simple_res = RES_W'(A & B);
         OP_XOR:  simple_res = RES_W'(A ^ B);
         default: simple_res = '0;
      endcase
   end

   // The result register is the last multiply stage, so the pipe itself holds one fewer.
   alu_mul_pipe #(
      .DATA_W (DATA_W),
      .STAGES (MUL_LAT - 1)
   ) u_mul_pipe (
      .clk       (clk),
      .rst_n     (rst_sync_n_q),
      .in_valid  (accept_mul),
      .a         (A),
      .b         (B),
      .out_valid (mul_valid),
      .out_prod  (mul_prod)
   );

   always_comb begin
      state_d  = state_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (is_simple) begin
                  result_d = simple_res;
                  done_d   = 1'b1;
                  state_d  = WAIT_LOW;
               end else if (is_mul) begin
                  state_d = MUL_BUSY;
               end else begin
                  state_d = WAIT_LOW;
               end
            end
         end
         MUL_BUSY: begin
            if (mul_valid) begin
               result_d = mul_prod;
               done_d   = 1'b1;
               state_d  = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_sync_n_q) begin
      if (!rst_sync_n_q) begin
         state_q  <= IDLE;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign done   = done_q;
   assign result = result_q;

   a_done_pulse : assert property (@(posedge clk) disable iff (!rst_sync_n_q)
      done_q |=> !done_q)
      else $error("done held high for two cycles");

   a_done_cause : assert property (@(posedge clk) disable iff (!rst_sync_n_q)
      done_q |-> (($past(state_q) == MUL_BUSY) ||
                  (($past(state_q) == IDLE) && $past(start) && $past(is_simple))))
      else $error("done without an accepted arithmetic command");

   a_result_stable : assert property (@(posedge clk) disable iff (!rst_sync_n_q)
      !done_q |-> $stable(result_q))
      else $error("result changed without done");

   a_op_known : assert property (@(posedge clk) disable iff (!rst_sync_n_q)
      ((state_q == IDLE) && start) |-> !$isunknown(op))
      else $error("start with unknown op");

endmodule

// File: tb/tb_tiny_alu_core.sv
// Bench for tiny_alu_core: directed boundary scenarios plus random commands against a plain
// arithmetic reference model with an expected-result queue.
module tb_tiny_alu_core;

   localparam int DATA_W  = 8;
   localparam int MUL_LAT = 3;
   localparam int BUDGET  = 20;

   logic        clk;
   logic        rst_n;
   logic [7:0]  a_i, b_i;
   logic [2:0]  op_i;
   logic        start;
   logic        done;
   logic [15:0] result;

   int          tests_run;
   int          tests_failed;
   logic [15:0] exp_q[$];
   logic [15:0] exp_last;

   tiny_alu_core #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .A      (a_i),
      .B      (b_i),
      .op     (op_i),
      .start  (start),
      .done   (done),
      .result (result)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] ref_alu(input logic [2:0] o, input logic [7:0] a,
                                           input logic [7:0] b);
      int unsigned x, y;
      x = a;
      y = b;
      case (o)
         3'd1:    return 16'(x + y);
         3'd2:    return 16'(x & y);
         3'd3:    return 16'(x ^ y);
         3'd4:    return 16'(x * y);
         default: return 16'h0000;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] o);
      return (o == 3'd4) ? MUL_LAT : 1;
   endfunction

   // drivers
   task automatic apply_reset();
      start = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Issue a command and hold start until done; lat = cycle after accept in which done is high.
   task automatic run_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input bit drop_early, output int lat, output logic [15:0] res,
                          output logic done_after);
      op_i  = o;
      a_i   = a;
      b_i   = b;
      start = 1'b1;
      lat   = 0;
      res   = '0;
      for (int n = 1; n <= BUDGET; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) begin
            a_i  = 8'($urandom);
            b_i  = 8'($urandom);
            op_i = 3'($urandom_range(0, 7));
            if (drop_early) start = 1'b0;
         end
         if (done) begin
            lat = n;
            res = result;
            break;
         end
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      done_after = done;
   endtask

   // Request held for one cycle only; counts done pulses over the following window.
   task automatic pulse_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                            output int dones);
      op_i  = o;
      a_i   = a;
      b_i   = b;
      start = 1'b1;
      dones = 0;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) dones++;
      repeat (MUL_LAT + 3) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
   endtask

   // scenarios
   task automatic test_reset();
      apply_reset();
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_done: got %b want 0", done);
      end
      tests_run++;
      if (result !== 16'h0000) begin
         tests_failed++;
         $display("FAIL reset_result: got %h want 0000", result);
      end
      exp_last = 16'h0000;
   endtask

   task automatic test_add_boundary();
      int lat;
      logic [15:0] res;
      logic da;
      run_cmd(3'd1, 8'hFF, 8'h01, 1'b0, lat, res, da);
      tests_run++;
      if (lat !== 1) begin
         tests_failed++;
         $display("FAIL add_latency: got %0d want 1", lat);
      end
      tests_run++;
      if (res !== 16'h0100) begin
         tests_failed++;
         $display("FAIL add_result: got %h want 0100", res);
      end
      tests_run++;
      if (da !== 1'b0) begin
         tests_failed++;
         $display("FAIL add_done_low: got %b want 0", da);
      end
   endtask

   task automatic test_mul();
      int lat;
      logic [15:0] res;
      logic da;
      run_cmd(3'd4, 8'hFF, 8'hFF, 1'b0, lat, res, da);
      tests_run++;
      if (lat !== MUL_LAT) begin
         tests_failed++;
         $display("FAIL mul_latency: got %0d want %0d", lat, MUL_LAT);
      end
      tests_run++;
      if (res !== 16'hFE01) begin
         tests_failed++;
         $display("FAIL mul_result: got %h want fe01", res);
      end
      tests_run++;
      if (da !== 1'b0) begin
         tests_failed++;
         $display("FAIL mul_done_low: got %b want 0", da);
      end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2;
      logic [15:0] res1, res2;
      logic da;
      run_cmd(3'd2, 8'hF0, 8'h3C, 1'b0, lat1, res1, da);
      run_cmd(3'd3, 8'hF0, 8'h3C, 1'b0, lat2, res2, da);
      tests_run++;
      if (lat1 !== 1 || res1 !== 16'h0030) begin
         tests_failed++;
         $display("FAIL and_cmd: got lat %0d res %h want lat 1 res 0030", lat1, res1);
      end
      tests_run++;
      if (lat2 !== 1 || res2 !== 16'h00CC) begin
         tests_failed++;
         $display("FAIL xor_cmd: got lat %0d res %h want lat 1 res 00cc", lat2, res2);
      end
      exp_last = 16'h00CC;
   endtask

   task automatic test_no_result_ops();
      int dones;
      pulse_cmd(3'd0, 8'h12, 8'h34, dones);
      tests_run++;
      if (dones !== 0) begin
         tests_failed++;
         $display("FAIL no_op_done: got %0d pulses want 0", dones);
      end
      tests_run++;
      if (result !== exp_last) begin
         tests_failed++;
         $display("FAIL no_op_result: got %h want %h", result, exp_last);
      end
      pulse_cmd(3'd5, 8'h56, 8'h78, dones);
      tests_run++;
      if (dones !== 0) begin
         tests_failed++;
         $display("FAIL illegal_done: got %0d pulses want 0", dones);
      end
      tests_run++;
      if (result !== exp_last) begin
         tests_failed++;
         $display("FAIL illegal_result: got %h want %h", result, exp_last);
      end
   endtask

   task automatic test_start_held();
      int dones, lat;
      logic [15:0] res;
      logic da;
      op_i  = 3'd1;
      a_i   = 8'h10;
      b_i   = 8'h20;
      start = 1'b1;
      dones = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      tests_run++;
      if (dones !== 1) begin
         tests_failed++;
         $display("FAIL held_start_pulses: got %0d want 1", dones);
      end
      tests_run++;
      if (result !== 16'h0030) begin
         tests_failed++;
         $display("FAIL held_start_result: got %h want 0030", result);
      end
      run_cmd(3'd1, 8'h01, 8'h02, 1'b0, lat, res, da);
      tests_run++;
      if (lat !== 1 || res !== 16'h0003) begin
         tests_failed++;
         $display("FAIL after_held_cmd: got lat %0d res %h want lat 1 res 0003", lat, res);
      end
   endtask

   task automatic test_mul_early_drop();
      int lat;
      logic [15:0] res;
      logic da;
      run_cmd(3'd4, 8'h0D, 8'hC8, 1'b1, lat, res, da);
      tests_run++;
      if (lat !== MUL_LAT) begin
         tests_failed++;
         $display("FAIL mul_drop_latency: got %0d want %0d", lat, MUL_LAT);
      end
      tests_run++;
      if (res !== 16'h0A28) begin
         tests_failed++;
         $display("FAIL mul_drop_result: got %h want 0a28", res);
      end
   endtask

   task automatic test_reset_mid_mul();
      int dones, lat;
      logic [15:0] res;
      logic da;
      op_i  = 3'd4;
      a_i   = 8'hFF;
      b_i   = 8'hFF;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (result !== 16'h0000 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset_clear: got done %b result %h want 0 0000", done, result);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      dones = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      tests_run++;
      if (dones !== 0) begin
         tests_failed++;
         $display("FAIL mid_reset_done: got %0d pulses want 0", dones);
      end
      tests_run++;
      if (result !== 16'h0000) begin
         tests_failed++;
         $display("FAIL mid_reset_result: got %h want 0000", result);
      end
      run_cmd(3'd1, 8'h02, 8'h03, 1'b0, lat, res, da);
      tests_run++;
      if (lat !== 1 || res !== 16'h0005) begin
         tests_failed++;
         $display("FAIL post_reset_add: got lat %0d res %h want lat 1 res 0005", lat, res);
      end
      exp_last = 16'h0005;
   endtask

   task automatic test_random();
      int lat, dones;
      logic [15:0] res, exp;
      logic da;
      logic [2:0] o;
      logic [7:0] a, b;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         a = 8'($urandom);
         b = 8'($urandom);
         if (o inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
            exp_q.push_back(ref_alu(o, a, b));
            run_cmd(o, a, b, 1'b0, lat, res, da);
            exp = exp_q.pop_front();
            tests_run++;
            if (lat !== ref_lat(o) || res !== exp) begin
               tests_failed++;
               $display("FAIL rand_cmd op=%0d a=%h b=%h: got lat %0d res %h want lat %0d res %h",
                        o, a, b, lat, res, ref_lat(o), exp);
            end
            exp_last = exp;
         end else begin
            pulse_cmd(o, a, b, dones);
            tests_run++;
            if (dones !== 0 || result !== exp_last) begin
               tests_failed++;
               $display("FAIL rand_noop op=%0d: got pulses %0d res %h want 0 res %h",
                        o, dones, result, exp_last);
            end
         end
      end
   endtask

   // sequence and report
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      start        = 1'b0;
      a_i          = '0;
      b_i          = '0;
      op_i         = '0;
      exp_last     = '0;
      test_reset();
      test_add_boundary();
      test_mul();
      test_back_to_back();
      test_no_result_ops();
      test_start_held();
      test_mul_early_drop();
      test_reset_mid_mul();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
